// File: rtl/instr_decode_queue_if.sv
// Fetch-to-decode bus: push side, head-entry decode fields, flush and occupancy.
// The queue owns the slave modport; the fetch/decode side drives the master modport.
interface instr_decode_queue_if #(
  parameter int DEPTH = 2,
  parameter int PC_W  = 32
);
  localparam int CW = $clog2(DEPTH + 1);

  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [PC_W-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [PC_W-1:0] out_pc;
  logic [5:0]      op;
  logic [4:0]      rs;
  logic [4:0]      rt;
  logic [4:0]      rd;
  logic [4:0]      shamt;
  logic [5:0]      funct;
  logic [15:0]     imm16;
  logic [31:0]     imm_ext;
  logic [25:0]     target26;
  logic [1:0]      fmt;
  logic [CW-1:0]   count;

  modport master (
    output flush, in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, op, rs, rt, rd, shamt, funct,
           imm16, imm_ext, target26, fmt, count
  );

  modport slave (
    input  flush, in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, op, rs, rt, rd, shamt, funct,
           imm16, imm_ext, target26, fmt, count
  );
endinterface

// File: rtl/instr_decode_queue.sv
// DEPTH-entry instruction/PC FIFO whose head is decoded combinationally; push at edge N is visible
// from edge N. in_ready is count<DEPTH only (a pop never frees a slot in the same cycle).
module instr_decode_queue #(
  parameter int DEPTH      = 2,
  parameter int PC_W       = 32,
  parameter int ZEXT_LOGIC = 1
) (
  input logic                 clk,
  input logic                 reset,
  instr_decode_queue_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     instr;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] cnt;
  logic          push;
  logic          pop;
  entry_t        head;
  logic [5:0]    head_op;
  logic [15:0]   head_imm;

  assign bus.in_ready  = (cnt < FULL);
  assign bus.out_valid = (cnt != '0);
  assign bus.count     = cnt;
  assign push = bus.in_valid && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;

  // DEPTH may be a non-power-of-two, so wrap with an explicit compare.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset || bus.flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      if (push && !pop)      cnt <= cnt + 1'b1;
      else if (pop && !push) cnt <= cnt - 1'b1;
    end
  end

  // Storage needs no reset: it is only observable through a non-zero count.
  always_ff @(posedge clk) begin
    if (push && !reset && !bus.flush) begin
      mem[wr_ptr] <= '{pc: bus.in_pc, instr: bus.in_instr};
    end
  end

  assign head     = bus.out_valid ? mem[rd_ptr] : '0;
  assign head_op  = head.instr[31:26];
  assign head_imm = head.instr[15:0];

  assign bus.out_pc   = head.pc;
  assign bus.op       = head_op;
  assign bus.rs       = head.instr[25:21];
  assign bus.rt       = head.instr[20:16];
  assign bus.rd       = head.instr[15:11];
  assign bus.shamt    = head.instr[10:6];
  assign bus.funct    = head.instr[5:0];
  assign bus.imm16    = head_imm;
  assign bus.target26 = head.instr[25:0];

  always_comb begin
    bus.fmt = 2'd1;
    if (!bus.out_valid)                         bus.fmt = 2'd0;
    else if (head_op == 6'h00)                  bus.fmt = 2'd0;
    else if (head_op == 6'h02 || head_op == 6'h03) bus.fmt = 2'd2;
  end

  // A zeroed head already yields a zero sign-extension, so no empty override is needed here.
  always_comb begin
    bus.imm_ext = {{16{head_imm[15]}}, head_imm};
    if (head_op == 6'h0F) begin
      bus.imm_ext = {head_imm, 16'h0000};
    end else if ((ZEXT_LOGIC != 0) &&
                 (head_op == 6'h0C || head_op == 6'h0D || head_op == 6'h0E)) begin
      bus.imm_ext = {16'h0000, head_imm};
    end
  end
endmodule

// File: tb/tb_instr_decode_queue.sv
// Scoreboard bench for instr_decode_queue: two instances (ZEXT_LOGIC 1 and 0) share the same stimulus.
module tb_instr_decode_queue;
  localparam int DEPTH = 2;
  localparam int PC_W  = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  instr_decode_queue_if #(.DEPTH(DEPTH), .PC_W(PC_W)) bus1 ();
  instr_decode_queue_if #(.DEPTH(DEPTH), .PC_W(PC_W)) bus0 ();

  instr_decode_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .ZEXT_LOGIC(1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1.slave));
  instr_decode_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .ZEXT_LOGIC(0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0.slave));

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   pops   = 0;
  logic acc;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] m_imm(input logic [31:0] ins, input bit zext);
    logic [5:0] o;
    o = ins[31:26];
    if (o == 6'h0F) return {ins[15:0], 16'h0000};
    if (zext && (o == 6'h0C || o == 6'h0D || o == 6'h0E)) return {16'h0000, ins[15:0]};
    return {{16{ins[15]}}, ins[15:0]};
  endfunction

  function automatic logic [1:0] m_fmt(input logic [31:0] ins);
    if (ins[31:26] == 6'h00) return 2'd0;
    if (ins[31:26] == 6'h02 || ins[31:26] == 6'h03) return 2'd2;
    return 2'd1;
  endfunction

  // One clock cycle: drive at negedge, compare head against the scoreboard, then update the model.
  task automatic cycle(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                       input logic ordy, input logic fl, input logic rst, output logic accepted);
    logic  exp_rdy;
    logic  do_pop;
    exp_t  e;
    @(negedge clk);
    reset = rst;
    bus1.in_valid = iv;   bus0.in_valid = iv;
    bus1.in_instr = ins;  bus0.in_instr = ins;
    bus1.in_pc    = pc;   bus0.in_pc    = pc;
    bus1.out_ready = ordy; bus0.out_ready = ordy;
    bus1.flush = fl;      bus0.flush = fl;
    #1;
    exp_rdy = (sb.size() < DEPTH);
    chk("in_ready", bus1.in_ready, exp_rdy);
    chk("out_valid", bus1.out_valid, sb.size() != 0);
    chk("count", bus1.count, sb.size());
    chk("out_valid_z0", bus0.out_valid, sb.size() != 0);
    if (sb.size() != 0) begin
      e = sb[0];
      chk("op", bus1.op, e.instr[31:26]);
      chk("rs", bus1.rs, e.instr[25:21]);
      chk("rt", bus1.rt, e.instr[20:16]);
      chk("rd", bus1.rd, e.instr[15:11]);
      chk("shamt", bus1.shamt, e.instr[10:6]);
      chk("funct", bus1.funct, e.instr[5:0]);
      chk("imm16", bus1.imm16, e.instr[15:0]);
      chk("target26", bus1.target26, e.instr[25:0]);
      chk("fmt", bus1.fmt, m_fmt(e.instr));
      chk("out_pc", bus1.out_pc, e.pc);
      chk("imm_ext_z1", bus1.imm_ext, m_imm(e.instr, 1'b1));
      chk("imm_ext_z0", bus0.imm_ext, m_imm(e.instr, 1'b0));
    end else begin
      chk("empty_flds", {bus1.op, bus1.rs, bus1.rt, bus1.rd, bus1.shamt, bus1.funct}, 64'd0);
      chk("empty_imm", {bus1.imm16, bus1.fmt, bus1.target26}, 64'd0);
      chk("empty_ext", bus1.imm_ext, 64'd0);
      chk("empty_pc", bus1.out_pc, 64'd0);
    end
    accepted = iv && exp_rdy && !fl && !rst;
    do_pop   = (sb.size() != 0) && ordy;
    if (fl || rst) begin
      sb.delete();
    end else begin
      if (do_pop) begin
        void'(sb.pop_front());
        pops++;
      end
      if (accepted) sb.push_back('{instr: ins, pc: pc});
    end
  endtask

  // Push one word into an empty queue, check its extension right after the edge, then pop it.
  task automatic probe(input logic [31:0] ins, input logic [31:0] pc,
                       input logic [31:0] ext1, input logic [31:0] ext0, input logic [1:0] f);
    logic a;
    cycle(1'b1, ins, pc, 1'b0, 1'b0, 1'b0, a);
    @(posedge clk); #2;
    chk("probe_ext_z1", bus1.imm_ext, ext1);
    chk("probe_ext_z0", bus0.imm_ext, ext0);
    chk("probe_fmt", bus1.fmt, f);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, a);
  endtask

  task automatic push_until(input logic [31:0] ins, input logic [31:0] pc, input logic ordy);
    logic a;
    a = 1'b0;
    for (int t = 0; t < 20 && !a; t++) cycle(1'b1, ins, pc, ordy, 1'b0, 1'b0, a);
    chk("push_timeout", a, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus1.in_valid = 0; bus0.in_valid = 0;
    bus1.in_instr = 0; bus0.in_instr = 0;
    bus1.in_pc = 0;    bus0.in_pc = 0;
    bus1.out_ready = 0; bus0.out_ready = 0;
    bus1.flush = 0;    bus0.flush = 0;
    repeat (2) @(posedge clk);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, acc);

    // R-type into an empty queue
    cycle(1'b1, 32'h012A4020, 32'h100, 1'b0, 1'b0, 1'b0, acc);
    @(posedge clk); #2;
    chk("t1_valid", bus1.out_valid, 1'b1);
    chk("t1_rs", bus1.rs, 5'd9);
    chk("t1_rt", bus1.rt, 5'd10);
    chk("t1_rd", bus1.rd, 5'd8);
    chk("t1_funct", bus1.funct, 6'h20);
    chk("t1_fmt", bus1.fmt, 2'd0);
    chk("t1_pc", bus1.out_pc, 32'h100);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, acc);

    // Immediate extension modes and J-type target
    probe(32'h2008FFFF, 32'h104, 32'hFFFFFFFF, 32'hFFFFFFFF, 2'd1);
    probe(32'h3508FFFF, 32'h108, 32'h0000FFFF, 32'hFFFFFFFF, 2'd1);
    probe(32'h3C081234, 32'h10C, 32'h12340000, 32'h12340000, 2'd1);
    probe(32'h0C100040, 32'h110, 32'h00000040, 32'h00000040, 2'd2);
    cycle(1'b1, 32'h0C100040, 32'h114, 1'b0, 1'b0, 1'b0, acc);
    @(posedge clk); #2;
    chk("jal_target", bus1.target26, 26'h0100040);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, acc);

    // Backpressure: third word is held by the source until decode drains
    push_until(32'h11111111, 32'h200, 1'b0);
    push_until(32'h22222222, 32'h204, 1'b0);
    for (int t = 0; t < 3; t++) begin
      cycle(1'b1, 32'h33333333, 32'h208, 1'b0, 1'b0, 1'b0, acc);
      chk("held_while_full", acc, 1'b0);
    end
    cycle(1'b1, 32'h33333333, 32'h208, 1'b1, 1'b0, 1'b0, acc);
    chk("full_pop_no_push", acc, 1'b0);
    push_until(32'h33333333, 32'h208, 1'b1);
    for (int t = 0; t < 4; t++) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, acc);

    // Streaming 20 words with continuous pop; pointers wrap repeatedly
    pops = 0;
    for (int i = 0; i < 20; i++) begin
      push_until(32'h8C000000 + i, 32'h400 + 4 * i, 1'b1);
      if (i > 0) chk("stream_count", bus1.count, 1);
    end
    for (int t = 0; t < 4; t++) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, acc);
    chk("stream_pops", pops, 20);

    // Flush with a concurrent push: queue empties and the push is dropped
    push_until(32'h24010001, 32'h500, 1'b0);
    push_until(32'h24020002, 32'h504, 1'b0);
    cycle(1'b1, 32'hDEADBEEF, 32'h508, 1'b0, 1'b1, 1'b0, acc);
    @(posedge clk); #2;
    chk("flush_count", bus1.count, 0);
    chk("flush_valid", bus1.out_valid, 1'b0);
    cycle(1'b1, 32'h24030003, 32'h50C, 1'b0, 1'b0, 1'b0, acc);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, acc);

    // Reset mid-stream behaves like flush
    push_until(32'h24040004, 32'h600, 1'b0);
    cycle(1'b1, 32'hCAFEF00D, 32'h608, 1'b0, 1'b0, 1'b1, acc);
    @(posedge clk); #2;
    chk("rst_count", bus1.count, 0);
    chk("rst_valid", bus1.out_valid, 1'b0);
    cycle(1'b1, 32'h24050005, 32'h60C, 1'b0, 1'b0, 1'b0, acc);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, acc);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, acc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
